// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_pkg
// Description : Shared types and constants for the memory-access stage:
//               writeback select, funct3 access sizes, FSM state encoding
//               and the writeback mux helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

    // Writeback source select; encoding 2'b11 falls back to the ALU value
    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_PC4  = 2'b10
    } wb_sel_e;

    // funct3 access size/sign codes; 011, 110 and 111 decode as word
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Memory-access FSM states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        RESP = 2'b10
    } mem_state_e;

    // Writeback value selection
    function automatic logic [31:0] wb_mux(
        input logic [1:0]  sel,
        input logic [31:0] alu,
        input logic [31:0] load,
        input logic [31:0] pc4
    );
        logic [31:0] v;
        case (sel)
            WB_LOAD: v = load;
            WB_PC4:  v = pc4;
            default: v = alu;
        endcase
        return v;
    endfunction

endpackage : pipeline_pkg
`default_nettype wire

// File: rtl/load_store_align.sv
`default_nettype none
// ============================================================================
// Module      : load_store_align
// Description : Combinational lane logic: byte enables, store-data
//               replication, load lane extract with sign/zero extension,
//               and misalignment detection.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_align
    import pipeline_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_data,
    output logic        o_misaligned
);

    logic [4:0]  w_shift;
    logic [31:0] w_rshift;

    assign w_shift  = {i_addr_lo, 3'b000};
    assign w_rshift = i_rdata >> w_shift;

    // Decode access size from funct3[1:0]; funct3[2] selects zero extension
    always_comb begin
        o_be         = 4'b1111;
        o_wdata      = i_wdata;
        o_load_data  = i_rdata;
        o_misaligned = 1'b0;
        case (i_funct3[1:0])
            2'b00: begin
                o_be        = 4'b0001 << i_addr_lo;
                o_wdata     = {4{i_wdata[7:0]}};
                o_load_data = i_funct3[2] ? {24'h0, w_rshift[7:0]}
                                          : {{24{w_rshift[7]}}, w_rshift[7:0]};
            end
            2'b01: begin
                o_be         = 4'b0011 << i_addr_lo;
                o_wdata      = {2{i_wdata[15:0]}};
                o_load_data  = i_funct3[2] ? {16'h0, w_rshift[15:0]}
                                           : {{16{w_rshift[15]}}, w_rshift[15:0]};
                o_misaligned = i_addr_lo[0];
            end
            default: begin
                o_misaligned = (i_addr_lo != 2'b00);
            end
        endcase
    end

endmodule : load_store_align
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage
// Description : Pipeline memory-access stage. Non-memory instructions retire
//               in one cycle; aligned loads/stores run a REQ/RESP handshake
//               on the data-memory port under a watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage
    import pipeline_pkg::*;
#(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] write_data_in,
    input  logic        data_write_en_in,
    input  logic        mem_read_en_in,
    input  logic [2:0]  funct3_in,
    input  logic        reg_write_in,
    input  logic [4:0]  rd_in,
    input  logic [31:0] pc_plus_four_in,
    input  logic [1:0]  alu_or_load_or_pc_plus_four_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        stall_out,
    output logic [31:0] wb_data_out,
    output logic [4:0]  wb_rd_out,
    output logic        wb_reg_write_out,
    output logic        misaligned_out,
    output logic        bus_err_out
);

    // Counter holds 0..MAX_WAIT-1; the access aborts in its MAX_WAIT-th cycle
    localparam int             CW         = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
    localparam logic [CW-1:0]  C_WDT_LAST = CW'(MAX_WAIT - 1);

    mem_state_e     r_state;
    logic [CW-1:0]  r_wdt;
    logic [2:0]     r_f3;
    logic [1:0]     r_addr_lo;
    logic [4:0]     r_rd;
    logic           r_reg_write;

    logic           w_mem;
    logic [2:0]     w_lsa_f3;
    logic [1:0]     w_lsa_addr;
    logic [3:0]     w_be;
    logic [31:0]    w_wdata_rep;
    logic [31:0]    w_load_data;
    logic           w_misaligned;

    assign w_mem      = data_write_en_in | mem_read_en_in;
    assign stall_out  = (r_state != IDLE);

    // Lane logic sees live inputs in IDLE and the captured access otherwise
    assign w_lsa_f3   = (r_state == IDLE) ? funct3_in           : r_f3;
    assign w_lsa_addr = (r_state == IDLE) ? alu_result_in[1:0]  : r_addr_lo;

    load_store_align u_align (
        .i_funct3     (w_lsa_f3),
        .i_addr_lo    (w_lsa_addr),
        .i_wdata      (write_data_in),
        .i_rdata      (dmem_rdata),
        .o_be         (w_be),
        .o_wdata      (w_wdata_rep),
        .o_load_data  (w_load_data),
        .o_misaligned (w_misaligned)
    );

    // Access FSM with registered bus and writeback outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state          <= IDLE;
            r_wdt            <= '0;
            r_f3             <= '0;
            r_addr_lo        <= '0;
            r_rd             <= '0;
            r_reg_write      <= 1'b0;
            dmem_req         <= 1'b0;
            dmem_we          <= 1'b0;
            dmem_addr        <= '0;
            dmem_wdata       <= '0;
            dmem_be          <= '0;
            wb_data_out      <= '0;
            wb_rd_out        <= '0;
            wb_reg_write_out <= 1'b0;
            misaligned_out   <= 1'b0;
            bus_err_out      <= 1'b0;
        end else begin
            wb_reg_write_out <= 1'b0;
            misaligned_out   <= 1'b0;
            bus_err_out      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (valid_in) begin
                        if (!w_mem) begin
                            wb_data_out      <= wb_mux(alu_or_load_or_pc_plus_four_in,
                                                       alu_result_in, w_load_data,
                                                       pc_plus_four_in);
                            wb_rd_out        <= rd_in;
                            wb_reg_write_out <= reg_write_in && (rd_in != 5'd0);
                        end else if (w_misaligned) begin
                            misaligned_out   <= 1'b1;
                        end else begin
                            // Store wins when both enables are set
                            r_state     <= REQ;
                            r_wdt       <= '0;
                            r_f3        <= funct3_in;
                            r_addr_lo   <= alu_result_in[1:0];
                            r_rd        <= rd_in;
                            r_reg_write <= reg_write_in;
                            dmem_req    <= 1'b1;
                            dmem_we     <= data_write_en_in;
                            dmem_addr   <= {alu_result_in[31:2], 2'b00};
                            dmem_wdata  <= w_wdata_rep;
                            dmem_be     <= w_be;
                        end
                    end
                end
                REQ: begin
                    // rvalid here is early and deliberately ignored
                    if (dmem_ready && dmem_we) begin
                        dmem_req <= 1'b0;
                        r_state  <= IDLE;
                    end else if (r_wdt == C_WDT_LAST) begin
                        dmem_req    <= 1'b0;
                        bus_err_out <= 1'b1;
                        r_state     <= IDLE;
                    end else begin
                        r_wdt <= r_wdt + 1'b1;
                        if (dmem_ready) begin
                            dmem_req <= 1'b0;
                            r_state  <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (dmem_rvalid) begin
                        wb_data_out      <= w_load_data;
                        wb_rd_out        <= r_rd;
                        wb_reg_write_out <= r_reg_write && (r_rd != 5'd0);
                        r_state          <= IDLE;
                    end else if (r_wdt == C_WDT_LAST) begin
                        bus_err_out <= 1'b1;
                        r_state     <= IDLE;
                    end else begin
                        r_wdt <= r_wdt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule : mem_access_stage
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_stage
// Description : Directed self-checking bench for mem_access_stage
//               (watchdog limit set to 4 cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

    logic        clk;
    logic        resetn;
    logic        valid_in;
    logic [31:0] alu_result_in;
    logic [31:0] write_data_in;
    logic        data_write_en_in;
    logic        mem_read_en_in;
    logic [2:0]  funct3_in;
    logic        reg_write_in;
    logic [4:0]  rd_in;
    logic [31:0] pc_plus_four_in;
    logic [1:0]  alu_or_load_or_pc_plus_four_in;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        stall_out;
    logic [31:0] wb_data_out;
    logic [4:0]  wb_rd_out;
    logic        wb_reg_write_out;
    logic        misaligned_out;
    logic        bus_err_out;

    int checks = 0;
    int errors = 0;

    mem_access_stage #(.MAX_WAIT(4)) dut (
        .clk                            (clk),
        .resetn                         (resetn),
        .valid_in                       (valid_in),
        .alu_result_in                  (alu_result_in),
        .write_data_in                  (write_data_in),
        .data_write_en_in               (data_write_en_in),
        .mem_read_en_in                 (mem_read_en_in),
        .funct3_in                      (funct3_in),
        .reg_write_in                   (reg_write_in),
        .rd_in                          (rd_in),
        .pc_plus_four_in                (pc_plus_four_in),
        .alu_or_load_or_pc_plus_four_in (alu_or_load_or_pc_plus_four_in),
        .dmem_req                       (dmem_req),
        .dmem_we                        (dmem_we),
        .dmem_addr                      (dmem_addr),
        .dmem_wdata                     (dmem_wdata),
        .dmem_be                        (dmem_be),
        .dmem_ready                     (dmem_ready),
        .dmem_rvalid                    (dmem_rvalid),
        .dmem_rdata                     (dmem_rdata),
        .stall_out                      (stall_out),
        .wb_data_out                    (wb_data_out),
        .wb_rd_out                      (wb_rd_out),
        .wb_reg_write_out               (wb_reg_write_out),
        .misaligned_out                 (misaligned_out),
        .bus_err_out                    (bus_err_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_in = 0; data_write_en_in = 0; mem_read_en_in = 0; reg_write_in = 0;
        funct3_in = 3'b000; rd_in = 5'd0; alu_result_in = 32'h0; write_data_in = 32'h0;
        pc_plus_four_in = 32'h0; alu_or_load_or_pc_plus_four_in = 2'b00;
    endtask

    initial begin
        resetn = 0;
        idle_inputs();
        dmem_ready = 0; dmem_rvalid = 0; dmem_rdata = 32'h0;

        // ---- reset state ----
        tick(); tick();
        chk("rst_stall",   32'(stall_out), 32'h0);
        chk("rst_req",     32'(dmem_req), 32'h0);
        chk("rst_wbdata",  wb_data_out, 32'h0);
        chk("rst_strobe",  32'(wb_reg_write_out), 32'h0);
        chk("rst_mis",     32'(misaligned_out), 32'h0);
        chk("rst_buserr",  32'(bus_err_out), 32'h0);
        resetn = 1;
        tick();

        // ---- ALU op, rd=5 ----
        valid_in = 1; alu_result_in = 32'h1234; rd_in = 5'd5; reg_write_in = 1;
        pc_plus_four_in = 32'h0000_0404;
        chk("alu_stall_pre", 32'(stall_out), 32'h0);
        tick();
        chk("alu_wbdata", wb_data_out, 32'h1234);
        chk("alu_rd",     32'(wb_rd_out), 32'd5);
        chk("alu_strobe", 32'(wb_reg_write_out), 32'h1);
        chk("alu_stall",  32'(stall_out), 32'h0);
        // PC+4 select, back-to-back
        alu_or_load_or_pc_plus_four_in = 2'b10;
        tick();
        chk("pc4_wbdata", wb_data_out, 32'h0000_0404);
        idle_inputs();
        tick();
        chk("alu_strobe_off", 32'(wb_reg_write_out), 32'h0);

        // ---- SB at 0x103, wd 0xAB, ready after 2 cycles ----
        valid_in = 1; data_write_en_in = 1; funct3_in = 3'b000;
        alu_result_in = 32'h103; write_data_in = 32'h0000_00AB; rd_in = 5'd6; reg_write_in = 1;
        tick();
        idle_inputs();
        chk("sb_req",   32'(dmem_req), 32'h1);
        chk("sb_we",    32'(dmem_we), 32'h1);
        chk("sb_addr",  dmem_addr, 32'h100);
        chk("sb_be",    32'(dmem_be), 32'h8);
        chk("sb_wdata", dmem_wdata, 32'hABAB_ABAB);
        chk("sb_stall", 32'(stall_out), 32'h1);
        tick();
        chk("sb_req_hold", 32'(dmem_req), 32'h1);
        dmem_ready = 1;
        tick();
        dmem_ready = 0;
        chk("sb_done_req",    32'(dmem_req), 32'h0);
        chk("sb_done_stall",  32'(stall_out), 32'h0);
        chk("sb_done_strobe", 32'(wb_reg_write_out), 32'h0);

        // ---- LB at 0x102, rdata 0x0080FF00 ----
        valid_in = 1; mem_read_en_in = 1; funct3_in = 3'b000; alu_result_in = 32'h102;
        rd_in = 5'd7; reg_write_in = 1; alu_or_load_or_pc_plus_four_in = 2'b01;
        tick();
        idle_inputs();
        chk("lb_req",  32'(dmem_req), 32'h1);
        chk("lb_we",   32'(dmem_we), 32'h0);
        chk("lb_addr", dmem_addr, 32'h100);
        dmem_ready = 1;
        tick();
        dmem_ready = 0;
        chk("lb_resp_req",   32'(dmem_req), 32'h0);
        chk("lb_resp_stall", 32'(stall_out), 32'h1);
        dmem_rvalid = 1; dmem_rdata = 32'h0080_FF00;
        tick();
        dmem_rvalid = 0;
        chk("lb_wbdata", wb_data_out, 32'hFFFF_FF80);
        chk("lb_rd",     32'(wb_rd_out), 32'd7);
        chk("lb_strobe", 32'(wb_reg_write_out), 32'h1);
        chk("lb_stall",  32'(stall_out), 32'h0);
        tick();
        chk("lb_strobe_off", 32'(wb_reg_write_out), 32'h0);

        // ---- LBU same access; ready+rvalid together in REQ must be ignored ----
        valid_in = 1; mem_read_en_in = 1; funct3_in = 3'b100; alu_result_in = 32'h102;
        rd_in = 5'd8; reg_write_in = 1; alu_or_load_or_pc_plus_four_in = 2'b01;
        tick();
        idle_inputs();
        dmem_ready = 1; dmem_rvalid = 1; dmem_rdata = 32'hFFFF_FFFF;
        tick();
        dmem_ready = 0; dmem_rvalid = 0;
        chk("lbu_early_strobe", 32'(wb_reg_write_out), 32'h0);
        chk("lbu_early_stall",  32'(stall_out), 32'h1);
        dmem_rvalid = 1; dmem_rdata = 32'h0080_FF00;
        tick();
        dmem_rvalid = 0;
        chk("lbu_wbdata", wb_data_out, 32'h0000_0080);
        chk("lbu_strobe", 32'(wb_reg_write_out), 32'h1);

        // ---- LH at 0x102 (upper half, sign extended) ----
        valid_in = 1; mem_read_en_in = 1; funct3_in = 3'b001; alu_result_in = 32'h102;
        rd_in = 5'd9; reg_write_in = 1;
        tick();
        idle_inputs();
        chk("lh_be", 32'(dmem_be), 32'hC);
        dmem_ready = 1;
        tick();
        dmem_ready = 0; dmem_rvalid = 1; dmem_rdata = 32'h8001_1234;
        tick();
        dmem_rvalid = 0;
        chk("lh_wbdata", wb_data_out, 32'hFFFF_8001);

        // ---- misaligned LW at 0x006 ----
        valid_in = 1; mem_read_en_in = 1; funct3_in = 3'b010; alu_result_in = 32'h006;
        rd_in = 5'd3; reg_write_in = 1;
        tick();
        chk("mis_pulse",  32'(misaligned_out), 32'h1);
        chk("mis_req",    32'(dmem_req), 32'h0);
        chk("mis_stall",  32'(stall_out), 32'h0);
        chk("mis_strobe", 32'(wb_reg_write_out), 32'h0);
        // ---- ALU op to rd=0 ----
        idle_inputs();
        valid_in = 1; alu_result_in = 32'h55; rd_in = 5'd0; reg_write_in = 1;
        tick();
        idle_inputs();
        chk("mis_pulse_off", 32'(misaligned_out), 32'h0);
        chk("rd0_strobe",    32'(wb_reg_write_out), 32'h0);
        chk("rd0_wbdata",    wb_data_out, 32'h55);

        // ---- watchdog: LW at 0x200, rvalid never arrives ----
        valid_in = 1; mem_read_en_in = 1; funct3_in = 3'b010; alu_result_in = 32'h200;
        rd_in = 5'd4; reg_write_in = 1;
        tick();
        idle_inputs();
        chk("wd_req", 32'(dmem_req), 32'h1);
        tick(); tick(); tick();
        chk("wd_still_req",   32'(dmem_req), 32'h1);
        chk("wd_no_err_yet",  32'(bus_err_out), 32'h0);
        tick();
        chk("wd_buserr", 32'(bus_err_out), 32'h1);
        chk("wd_req_off", 32'(dmem_req), 32'h0);
        chk("wd_stall",  32'(stall_out), 32'h0);
        chk("wd_strobe", 32'(wb_reg_write_out), 32'h0);
        tick();
        chk("wd_buserr_off", 32'(bus_err_out), 32'h0);

        // ---- reset during RESP, then a late rvalid ----
        valid_in = 1; mem_read_en_in = 1; funct3_in = 3'b010; alu_result_in = 32'h300;
        rd_in = 5'd9; reg_write_in = 1;
        tick();
        idle_inputs();
        dmem_ready = 1;
        tick();
        dmem_ready = 0;
        chk("rr_in_resp", 32'(stall_out), 32'h1);
        resetn = 0;
        #1;
        chk("rr_stall",  32'(stall_out), 32'h0);
        chk("rr_wbdata", wb_data_out, 32'h0);
        chk("rr_addr",   dmem_addr, 32'h0);
        #1;
        resetn = 1;
        dmem_rvalid = 1; dmem_rdata = 32'hDEAD_BEEF;
        tick();
        dmem_rvalid = 0;
        chk("rr_late_strobe", 32'(wb_reg_write_out), 32'h0);
        chk("rr_late_wbdata", wb_data_out, 32'h0);
        chk("rr_late_stall",  32'(stall_out), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mem_access_stage
`default_nettype wire
